apb_rr_master: RTL and testbench
================================

Name: apb_rr_master

Overview:
- Shares one APB slave port among NUM_REQ internal requesters.
- Each requester uses a simple valid/ready request channel and a one-cycle response pulse.
- A round-robin arbiter selects one request at a time. The block then drives a full APB SETUP/ACCESS transfer, honours PREADY wait states, and aborts a transfer with an error if the slave never responds.
- Sits between bus-mastering blocks (DMA, config sequencer, debug port) and the 8-bit-address / 32-bit-data APB RAM slave.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_WIDTH, 8, APB address width.
- DATA_WIDTH, 32, APB data width.
- TIMEOUT, 16, max ACCESS cycles with PREADY low before abort; 0 disables the timeout.

Ports:
- PCLK  in  1  APB clock; all logic on rising edge.
- PRESETn  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester request pending.
- req_write  in  NUM_REQ  per-requester 1=write, 0=read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at slice i.
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
- req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse.
- rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid.
- rsp_err  out  1  timeout flag, valid with rsp_valid.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_WIDTH  APB address.
- PWDATA  out  DATA_WIDTH  APB write data.
- PRDATA  in  DATA_WIDTH  APB read data.
- PREADY  in  1  APB ready.

Behaviour:
- Reset (async, PRESETn=0):
  - State=IDLE.
  - Round-robin pointer=0, timeout counter=0.
  - All outputs 0, including PADDR/PWDATA/rsp_rdata.
  - A transfer in flight is dropped immediately; no rsp_valid is ever issued for it.
- All outputs are registered.
- FSM IDLE:
  - If any req_valid is high, grant g = first set bit at or after the pointer, wrapping modulo NUM_REQ.
  - Latch req_write[g], address slice g and wdata slice g into PWRITE/PADDR/PWDATA.
  - Pointer <= (g+1) mod NUM_REQ, then go to SETUP.
  - If no req_valid is high, stay in IDLE; the pointer is unchanged.
- FSM SETUP (exactly 1 cycle):
  - PSEL=1, PENABLE=0, req_ready[g]=1.
  - Always go to ACCESS.
- FSM ACCESS:
  - PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA held stable.
  - PREADY=1 sampled: go to IDLE. Next cycle rsp_valid[g]=1, rsp_err=0, rsp_rdata=PRDATA for reads, 0 for writes.
  - PREADY=0: counter++. When the counter reaches TIMEOUT (with TIMEOUT≠0), go to IDLE. Next cycle rsp_valid[g]=1, rsp_err=1, rsp_rdata=0.
  - The counter clears on entering SETUP.
- PSEL/PENABLE are 0 in IDLE. Minimum transfer is IDLE→SETUP→ACCESS = 3 cycles, so there is at least one idle cycle between transfers.
- A new grant may be made in the same IDLE cycle in which rsp_valid is high.
- Requester contract:
  - Hold req_valid and request fields stable until req_ready is seen.
  - Fields are sampled at the IDLE→SETUP edge.
  - req_valid still high after the req_ready cycle is a new request.
- Simultaneous requests: strict round-robin. No requester waits more than NUM_REQ-1 other transfers.
- Invariants:
  - At most one bit of req_ready or rsp_valid is set at any time.
  - rsp_valid for a requester never precedes its req_ready.
- Illegal FSM encodings return to IDLE with no outputs asserted.

Decomposition:
- Shared package apb_pkg:
  - State encoding constants: IDLE/SETUP/ACCESS.
  - ADDRWIDTH/DATAWIDTH defaults (8/32), shared with the APB slave.
  - Response error code constant.
- Sub-module rr_arbiter:
  - Parameter N; inputs req[N], pointer; outputs one-hot grant and grant index.
  - Purely combinational, reusable by other bus arbiters.
- Pointer and FSM stay in apb_rr_master.

Test Plan:
- Single write: req 1 writes addr 0x10 / data 0xDEADBEEF, PREADY=1 in first ACCESS → PSEL 2 cycles, PENABLE 1 cycle, PADDR=0x10, PWDATA=0xDEADBEEF; rsp_valid[1] one cycle later, rsp_err=0.
- Read with wait states: req 0 reads 0x10, PREADY low for 3 ACCESS cycles then high with PRDATA=0xDEADBEEF → PADDR stable across all 4 ACCESS cycles; rsp_rdata=0xDEADBEEF, rsp_err=0.
- Contention: all 4 requesters valid from reset → grants in order 0,1,2,3,0. With req 2 alone re-requesting after grant 3, next grant is 2 and pointer becomes 3.
- Timeout: TIMEOUT=16, PREADY tied 0 → ACCESS lasts exactly 16 cycles; rsp_valid pulse with rsp_err=1, rsp_rdata=0; the next request proceeds normally.
- Reset mid-transfer: PRESETn low during ACCESS → PSEL/PENABLE/req_ready/rsp_valid go 0 without waiting for a clock; no rsp_valid after release; first grant after reset goes to lowest-index valid requester.
- Integration with the APB RAM slave: write 0x12345678 to 0x20, then read 0x20 → rsp_rdata equals the slave RAM contents. Flag the slave's 30-bit write truncation as a mismatch (expect 0x12345678).

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, default bus widths and response codes.
// Used by the round-robin master and the APB RAM slave.
package apb_pkg;

  localparam int ADDRWIDTH = 8;
  localparam int DATAWIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam logic RSP_OK          = 1'b0;
  localparam logic RSP_ERR_TIMEOUT = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr,
// wrapping modulo N. Reusable by any bus arbiter that keeps its own pointer.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  int   idx;
  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/apb_rr_master.sv
// Shares one APB slave port among NUM_REQ requesters: round-robin grant, full
// SETUP/ACCESS transfer with PREADY wait states and an optional stall timeout.
module apb_rr_master
  import apb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = ADDRWIDTH,
  parameter int DATA_WIDTH = DATAWIDTH,
  parameter int TIMEOUT    = 16
) (
  input  logic                          PCLK,
  input  logic                          PRESETn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic                          PSEL,
  output logic                          PENABLE,
  output logic                          PWRITE,
  output logic [ADDR_WIDTH-1:0]         PADDR,
  output logic [DATA_WIDTH-1:0]         PWDATA,
  input  logic [DATA_WIDTH-1:0]         PRDATA,
  input  logic                          PREADY
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  apb_state_e           state;
  logic [IW-1:0]        ptr;
  logic [CW-1:0]        tmo_cnt;
  logic [NUM_REQ-1:0]   gnt_oh;
  logic [NUM_REQ-1:0]   gnt_sel;
  logic [IW-1:0]        gnt_idx;
  logic [IW-1:0]        ptr_next;
  logic [CW-1:0]        tmo_next;
  logic                 tmo_hit;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (gnt_sel),
    .grant_idx (gnt_idx)
  );

  assign ptr_next = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  assign tmo_next = tmo_cnt + 1'b1;
  // TIMEOUT of zero disables the abort; the counter may wrap harmlessly.
  assign tmo_hit  = (TIMEOUT != 0) && (tmo_next == CW'(TIMEOUT));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      ptr       <= '0;
      tmo_cnt   <= '0;
      gnt_oh    <= '0;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            gnt_oh    <= gnt_sel;
            ptr       <= ptr_next;
            PWRITE    <= req_write[gnt_idx];
            PADDR     <= req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
            PWDATA    <= req_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
            PSEL      <= 1'b1;
            PENABLE   <= 1'b0;
            req_ready <= gnt_sel;
            tmo_cnt   <= '0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= gnt_oh;
            rsp_err   <= RSP_OK;
            rsp_rdata <= PWRITE ? '0 : PRDATA;
            state     <= IDLE;
          end else begin
            tmo_cnt <= tmo_next;
            if (tmo_hit) begin
              PSEL      <= 1'b0;
              PENABLE   <= 1'b0;
              rsp_valid <= gnt_oh;
              rsp_err   <= RSP_ERR_TIMEOUT;
              rsp_rdata <= '0;
              state     <= IDLE;
            end
          end
        end
        default: begin
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          rsp_err <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_rr_master.sv
// Scoreboard bench for apb_rr_master with a behavioural APB RAM slave
// (configurable wait states, or stuck-not-ready to force the timeout).
module tb_apb_rr_master;

  localparam int N   = 4;
  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic [N-1:0]    req_valid, req_write, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, PWDATA, PRDATA;
  logic            rsp_err, PSEL, PENABLE, PWRITE, PREADY;
  logic [AW-1:0]   PADDR;

  logic [AW-1:0] t_addr  [N];
  logic [DW-1:0] t_wdata [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_pack
    assign req_addr[gi*AW +: AW]  = t_addr[gi];
    assign req_wdata[gi*DW +: DW] = t_wdata[gi];
  end

  apb_rr_master #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
    .PCLK(clk), .PRESETn(rstn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 clk = ~clk;

  // Behavioural APB RAM slave, full 32-bit storage.
  logic [DW-1:0] mem [256];
  int acc_cnt = 0;
  int waits   = 0;
  bit stuck   = 1'b0;

  assign PREADY = PSEL && PENABLE && !stuck && (acc_cnt == waits);
  assign PRDATA = mem[PADDR];

  always @(posedge clk) begin
    if (PSEL && PENABLE) begin
      if (PREADY) begin
        acc_cnt <= 0;
        if (PWRITE) mem[PADDR] <= PWDATA;
      end else begin
        acc_cnt <= acc_cnt + 1;
      end
    end else begin
      acc_cnt <= 0;
    end
  end

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  int   gnt_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string msg);
    checks++;
    errors++;
    $display("FAIL %s", msg);
  endtask

  task automatic expect_rsp(input int r, input logic [31:0] d, input logic e);
    rsp_t x;
    x.idx = r; x.rdata = d; x.err = e;
    exp_q.push_back(x);
  endtask

  task automatic issue(input int r, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit seen;
    seen = 1'b0;
    t_addr[r]    = a;
    t_wdata[r]   = d;
    req_write[r] = wr;
    req_valid[r] = 1'b1;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clk);
      if (req_ready[r]) seen = 1'b1;
    end
    if (!seen) fail($sformatf("ready_timeout r%0d: got no req_ready, expected one within 300 cycles", r));
    @(posedge clk);
    #1 req_valid[r] = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || gnt_q.size() != 0 || PSEL) && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (n >= 600)
      fail($sformatf("done_timeout: %0d responses still pending, expected 0", exp_q.size()));
    repeat (2) @(negedge clk);
  endtask

  // Monitor: grant order, APB phase shape and responses.
  int            psel_cnt, pen_cnt, last_psel, last_pen;
  logic [AW-1:0] snap_addr;
  logic [DW-1:0] snap_wdata;
  logic          snap_write;
  logic          prev_psel, prev_pen;
  int            mon_g, mon_r, mon_k, mon_e;

  initial begin
    prev_psel = 1'b0; prev_pen = 1'b0;
    psel_cnt = 0; pen_cnt = 0; last_psel = 0; last_pen = 0;
    forever begin
      @(negedge clk);
      if (req_ready != '0) begin
        chk("ready_onehot", 64'($onehot(req_ready)), 64'd1);
        mon_g = 0;
        for (int i = 0; i < N; i++) if (req_ready[i]) mon_g = i;
        if (gnt_q.size() == 0) fail($sformatf("grant_unexpected: got grant r%0d, expected none", mon_g));
        else begin
          mon_e = gnt_q.pop_front();
          chk("grant_order", 64'(mon_g), 64'(mon_e));
        end
        chk("setup_phase", {PSEL, PENABLE}, 2'b10);
        chk("setup_addr", PADDR, t_addr[mon_g]);
        chk("setup_wdata", PWDATA, t_wdata[mon_g]);
        chk("setup_write", PWRITE, req_write[mon_g]);
        snap_addr = PADDR; snap_wdata = PWDATA; snap_write = PWRITE;
        psel_cnt = 1; pen_cnt = 0;
      end else if (PSEL && PENABLE) begin
        psel_cnt++;
        pen_cnt++;
        chk("access_hold", {PWRITE, PADDR, PWDATA}, {snap_write, snap_addr, snap_wdata});
      end else if (PSEL) begin
        fail("setup_no_ready: got PSEL without req_ready, expected req_ready in SETUP");
      end
      if (!PSEL && prev_psel) begin
        last_psel = psel_cnt;
        last_pen  = pen_cnt;
      end
      if (rsp_valid != '0) begin
        chk("rsp_onehot", 64'($onehot(rsp_valid)), 64'd1);
        chk("rsp_timing", {prev_pen, PSEL}, 2'b10);
        mon_r = 0;
        for (int i = 0; i < N; i++) if (rsp_valid[i]) mon_r = i;
        mon_k = -1;
        for (int k = 0; k < exp_q.size(); k++)
          if (mon_k < 0 && exp_q[k].idx == mon_r) mon_k = k;
        if (mon_k < 0) fail($sformatf("rsp_unexpected: got rsp for r%0d, expected none", mon_r));
        else begin
          chk($sformatf("rsp_rdata_r%0d", mon_r), rsp_rdata, exp_q[mon_k].rdata);
          chk($sformatf("rsp_err_r%0d", mon_r), rsp_err, exp_q[mon_k].err);
          exp_q.delete(mon_k);
        end
      end
      prev_psel = PSEL;
      prev_pen  = PSEL && PENABLE;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run still active at 100000 ns, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b0;
    req_valid = '0;
    req_write = '0;
    for (int i = 0; i < N; i++) begin
      t_addr[i] = '0;
      t_wdata[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {PSEL, PENABLE, PWRITE, rsp_err, req_ready, rsp_valid}, 64'd0);
    chk("rst_paddr", PADDR, 64'd0);
    chk("rst_pwdata", PWDATA, 64'd0);
    chk("rst_rdata", rsp_rdata, 64'd0);
    rstn = 1'b1;

    // All four requesters at once from reset: 0,1,2,3.
    for (int i = 0; i < N; i++) gnt_q.push_back(i);
    expect_rsp(0, 32'h0, 1'b0);
    expect_rsp(1, 32'h0, 1'b0);
    expect_rsp(2, 32'h0, 1'b0);
    expect_rsp(3, 32'h0, 1'b0);
    fork
      issue(0, 1'b1, 8'h01, 32'h11111111);
      issue(1, 1'b1, 8'h02, 32'h22222222);
      issue(2, 1'b1, 8'h03, 32'h33333333);
      issue(3, 1'b1, 8'h04, 32'h44444444);
    join
    gnt_q.push_back(0);
    expect_rsp(0, 32'h33333333, 1'b0);
    issue(0, 1'b0, 8'h03, 32'h0);
    // Pointer is 1 here; req 2 alone wins and moves the pointer to 3.
    gnt_q.push_back(2);
    expect_rsp(2, 32'h11111111, 1'b0);
    issue(2, 1'b0, 8'h01, 32'h0);
    gnt_q.push_back(3);
    gnt_q.push_back(0);
    expect_rsp(3, 32'h44444444, 1'b0);
    expect_rsp(0, 32'h0, 1'b0);
    fork
      issue(0, 1'b1, 8'h05, 32'h55555555);
      issue(3, 1'b0, 8'h04, 32'h0);
    join
    wait_done();

    // Single zero-wait write.
    gnt_q.push_back(1);
    expect_rsp(1, 32'h0, 1'b0);
    issue(1, 1'b1, 8'h10, 32'hDEADBEEF);
    wait_done();
    chk("wr_psel_cycles", 64'(last_psel), 64'd2);
    chk("wr_penable_cycles", 64'(last_pen), 64'd1);
    chk("wr_paddr", snap_addr, 64'h10);
    chk("wr_pwdata", snap_wdata, 64'hDEADBEEF);

    // Read with three wait states.
    waits = 3;
    gnt_q.push_back(0);
    expect_rsp(0, 32'hDEADBEEF, 1'b0);
    issue(0, 1'b0, 8'h10, 32'h0);
    wait_done();
    chk("wait_penable_cycles", 64'(last_pen), 64'd4);
    waits = 0;

    // Slave never ready: abort after exactly TMO ACCESS cycles.
    stuck = 1'b1;
    gnt_q.push_back(3);
    expect_rsp(3, 32'h0, 1'b1);
    issue(3, 1'b1, 8'h30, 32'hCAFEF00D);
    wait_done();
    chk("tmo_penable_cycles", 64'(last_pen), 64'd16);
    stuck = 1'b0;
    gnt_q.push_back(1);
    expect_rsp(1, 32'hDEADBEEF, 1'b0);
    issue(1, 1'b0, 8'h10, 32'h0);
    wait_done();
    chk("post_tmo_penable_cycles", 64'(last_pen), 64'd1);

    // Write/read through the RAM slave; all 32 bits must survive.
    gnt_q.push_back(2);
    gnt_q.push_back(2);
    expect_rsp(2, 32'h0, 1'b0);
    expect_rsp(2, 32'h12345678, 1'b0);
    issue(2, 1'b1, 8'h20, 32'h12345678);
    issue(2, 1'b0, 8'h20, 32'h0);
    wait_done();

    // Reset during ACCESS; the dropped transfer never responds.
    stuck = 1'b1;
    gnt_q.push_back(1);
    issue(1, 1'b1, 8'h40, 32'hBAD0BAD0);
    repeat (3) @(negedge clk);
    chk("mid_in_access", {PSEL, PENABLE}, 2'b11);
    #1 rstn = 1'b0;
    #1;
    chk("rstmid_ctrl", {PSEL, PENABLE, req_ready, rsp_valid}, 64'd0);
    chk("rstmid_paddr", PADDR, 64'd0);
    stuck = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    // Pointer was 2 before reset; after reset req 0 must win over req 3.
    gnt_q.push_back(0);
    gnt_q.push_back(3);
    expect_rsp(0, 32'h55555555, 1'b0);
    expect_rsp(3, 32'h0, 1'b0);
    fork
      issue(3, 1'b1, 8'h06, 32'h66666666);
      issue(0, 1'b0, 8'h05, 32'h0);
    join
    wait_done();
    repeat (20) @(negedge clk);
    chk("queues_empty", 64'(exp_q.size() + gnt_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
